simple_multi_fifo: RTL and testbench
====================================

# simple_multi_fifo

Multi-channel successor to the single-queue synchronous FIFO. It holds CHANNELS independent first-word-fall-through queues. Each queue has its own valid/ready ports, per-channel clear, item count, full/empty flags and a programmable almost-full flag. It sits between per-core producers and a shared consumer, such as a scheduler or DMA arbiter, wherever the design previously instantiated one FIFO per core.

## Interface
Parameters:
- CHANNELS, 4: number of independent queues.
- ADDR_WIDTH, 5: log2 of per-channel depth, so each queue holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width.
- AFULL_THRESH, 2**ADDR_WIDTH-4: almost_full asserts when the count is at or above this value. Legal range is 1..2**ADDR_WIDTH.

Ports (bus slice i belongs to channel i; data slice i is [i*DATA_WIDTH +: DATA_WIDTH]):
- clk  in  1  sole clock; everything is posedge.
- rst_n  in  1  synchronous, active-low reset.
- clear  in  CHANNELS  per-channel synchronous flush.
- din_valid  in  CHANNELS  write request.
- din  in  CHANNELS*DATA_WIDTH  write data.
- din_ready  out  CHANNELS  queue can accept a word.
- dout_valid  out  CHANNELS  head word present.
- dout  out  CHANNELS*DATA_WIDTH  head word of each queue.
- dout_ready  in  CHANNELS  consumer accepts the head word.
- item_count  out  CHANNELS*(ADDR_WIDTH+1)  occupancy of each queue.
- full  out  CHANNELS  queue is full.
- empty  out  CHANNELS  queue is empty.
- almost_full  out  CHANNELS  occupancy is at or above AFULL_THRESH.

## Operation
- Per channel i:
  - enq_i = din_valid[i] & din_ready[i].
  - deq_i = dout_valid[i] & dout_ready[i].
- Each channel keeps rptr and wptr (ADDR_WIDTH bits each, wrap modulo 2**ADDR_WIDTH) and count (ADDR_WIDTH+1 bits).
- Storage is one memory array per channel.
- On enq: mem[wptr] <= din slice, and wptr increments.
- On deq: rptr increments.
- count rules:
  - enq only: +1.
  - deq only: −1.
  - both or neither: unchanged.
- full_r and empty_r are updated only when enq XOR deq:
  - full_r <= enq & (wptr+1 == rptr).
  - empty_r <= deq & (rptr+1 == wptr).
- Outputs:
  - full = full_r; empty = empty_r; dout_valid = ~empty_r.
  - din_ready = ~full_r & rst_n & ~clear[i].
  - dout slice = mem[rptr], an unregistered read.
- almost_full is registered and computed from the next-state count, so it stays consistent with item_count every cycle.
- Channels are fully independent. There is no cross-channel arbitration, and a channel's state never depends on another channel's inputs.
- Reset (rst_n = 0), or clear[i] for one channel:
  - Pointers and count go to 0; full=0, empty=1, almost_full=0.
  - din_ready=0, dout_valid=0.
  - Memory contents are not reset.
- Boundaries:
  - Write while full: din_ready=0, the word is not written and nothing changes.
  - Read while empty: dout_valid=0, no change.
  - Simultaneous enq+deq with 1 ≤ count ≤ depth−1: count is held and both pointers advance.
  - Simultaneous enq+deq at count = depth is impossible, because din_ready=0.
  - At count = 0 a simultaneous enq+deq cannot occur, because dout_valid=0.
  - Pointer wrap from 2**ADDR_WIDTH−1 to 0 is seamless.
  - clear[i] during an in-flight enq or deq: clear wins and the transfer is discarded.
  - Reset mid-operation: all queues flush on that edge.

## Timing
- Write-to-read latency is 1 cycle. A word accepted at edge N has dout_valid=1 and valid dout after edge N.
- Read is fall-through: dout is valid in the same cycle as dout_valid, and it advances to the next word on the edge where deq fires.
- full, empty, item_count and almost_full all reflect the transfers of edge N immediately after edge N.
- din_ready drops combinationally during reset or clear. Otherwise it changes only on clock edges.
- Full throughput is one enq and one deq per channel per cycle, on all channels concurrently.

## Configuration
- Macro: SIMPLE_MULTI_FIFO_STATS_EN.
- When defined:
  - Extra output stall_count, CHANNELS*16 bits. Per channel it is a saturating counter, incremented every cycle with din_valid[i] & ~din_ready[i] while rst_n=1.
  - Extra input stats_clr, CHANNELS bits, which zeroes the channel's counter synchronously. clear[i] does not affect the counter.
  - The counter resets to 0 on rst_n=0 and saturates at 16'hFFFF.
- When not defined: neither port exists, no counters are built, and the block's behaviour is otherwise identical.

## Test plan
- Defaults, channel 0 fill: write 32 words 0..31 with dout_ready=0. Required:
  - full[0]=1 after the 32nd edge, item_count[0]=32, din_ready[0]=0.
  - almost_full[0] rises after the 28th write.
  - Channels 1–3 stay empty=1.
- Drain: after the fill, set dout_ready[0]=1 for 32 cycles. Required:
  - dout reads 0..31 in order, with dout_valid continuous.
  - Ends with empty[0]=1 and count 0.
- Wrap plus concurrent traffic: hold count at 5 while streaming 100 words with simultaneous enq and deq every cycle. Required:
  - count stays 5 throughout.
  - Output sequence equals input sequence delayed by 5 words.
  - Both pointers wrap three times.
- Per-channel clear: fill channels 1 and 2 with 10 words each, then pulse clear[1] for 1 cycle concurrent with din_valid[1]=1. Required:
  - Channel 1 ends with count 0, empty=1, and the new word dropped.
  - Channel 2 still has count 10.
- Reset mid-operation: drive rst_n=0 for 1 cycle with all channels half full and active. Required:
  - All counts 0, empty=1, full=0, almost_full=0.
  - din_ready=0 while rst_n=0.
  - The first write after release appears after 1 cycle.
- With SIMPLE_MULTI_FIFO_STATS_EN defined: hold din_valid[3]=1 for 40 cycles into a full channel 3. Required:
  - stall_count[3] = 40.
  - stats_clr[3] returns it to 0.
  - Other channels' counters stay 0.

Source files
------------

// File: rtl/simple_multi_fifo.sv
// simple_multi_fifo: CHANNELS independent first-word-fall-through queues,
// each with its own valid/ready handshakes, per-channel flush, occupancy,
// full/empty flags and a programmable almost-full flag.
// Optional feature: define SIMPLE_MULTI_FIFO_STATS_EN to add per-channel
// saturating stall counters (stall_count) with a per-channel clear (stats_clr).

module simple_multi_fifo_ch #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int AFULL_THRESH = 2**ADDR_WIDTH-4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  din_valid,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  din_ready,
   output logic                  dout_valid,
   output logic [DATA_WIDTH-1:0] dout,
   input  logic                  dout_ready,
   output logic [ADDR_WIDTH:0]   item_count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full
`ifdef SIMPLE_MULTI_FIFO_STATS_EN
   ,
   input  logic                  stats_clr,
   output logic [15:0]           stall_count
`endif
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   // Threshold can equal DEPTH, so it needs the same width as the count.
   localparam logic [ADDR_WIDTH:0] THRESH = (ADDR_WIDTH+1)'(AFULL_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] rptr, wptr, rptr_inc, wptr_inc;
   logic [ADDR_WIDTH:0]   count, count_nxt;
   logic                  full_r, empty_r, afull_r;
   logic                  enq, deq;

   // din_ready falls combinationally while the queue is being flushed so a
   // producer never sees a transfer that the flush is about to discard.
   assign din_ready   = ~full_r & rst_n & ~clear;
   assign dout_valid  = ~empty_r;
   assign enq         = din_valid & din_ready;
   assign deq         = dout_valid & dout_ready;
   // Increments kept at pointer width so the wrap compare is modulo depth.
   assign rptr_inc    = rptr + 1'b1;
   assign wptr_inc    = wptr + 1'b1;
   assign dout        = mem[rptr];
   assign item_count  = count;
   assign full        = full_r;
   assign empty       = empty_r;
   assign almost_full = afull_r;

   // Next occupancy; simultaneous enq+deq leaves it unchanged.
   always_comb begin
      count_nxt = count;
      if (enq && !deq)      count_nxt = count + 1'b1;
      else if (deq && !enq) count_nxt = count - 1'b1;
   end

   // Pointer/flag state; reset and clear both flush, clear beats any transfer.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         rptr    <= '0;
         wptr    <= '0;
         count   <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
         afull_r <= 1'b0;
      end else begin
         if (enq) wptr <= wptr_inc;
         if (deq) rptr <= rptr_inc;
         count   <= count_nxt;
         afull_r <= (count_nxt >= THRESH);
         if (enq ^ deq) begin
            full_r  <= enq & (wptr_inc == rptr);
            empty_r <= deq & (rptr_inc == wptr);
         end
      end
   end

   // Storage write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (enq) mem[wptr] <= din;
   end

`ifdef SIMPLE_MULTI_FIFO_STATS_EN
   // Saturating count of cycles a producer was held off; flush does not touch it.
   always_ff @(posedge clk) begin
      if (!rst_n || stats_clr)                              stall_count <= '0;
      else if (din_valid && !din_ready && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
   end
`endif

endmodule

module simple_multi_fifo #(
   parameter int CHANNELS     = 4,
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int AFULL_THRESH = 2**ADDR_WIDTH-4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [CHANNELS-1:0]              clear,
   input  logic [CHANNELS-1:0]              din_valid,
   input  logic [CHANNELS*DATA_WIDTH-1:0]   din,
   output logic [CHANNELS-1:0]              din_ready,
   output logic [CHANNELS-1:0]              dout_valid,
   output logic [CHANNELS*DATA_WIDTH-1:0]   dout,
   input  logic [CHANNELS-1:0]              dout_ready,
   output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] item_count,
   output logic [CHANNELS-1:0]              full,
   output logic [CHANNELS-1:0]              empty,
   output logic [CHANNELS-1:0]              almost_full
`ifdef SIMPLE_MULTI_FIFO_STATS_EN
   ,
   input  logic [CHANNELS-1:0]              stats_clr,
   output logic [CHANNELS*16-1:0]           stall_count
`endif
);

   localparam int CW = ADDR_WIDTH + 1;

   // One fully independent queue per channel.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      simple_multi_fifo_ch #(
         .ADDR_WIDTH   (ADDR_WIDTH),
         .DATA_WIDTH   (DATA_WIDTH),
         .AFULL_THRESH (AFULL_THRESH)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .clear       (clear[i]),
         .din_valid   (din_valid[i]),
         .din         (din[i*DATA_WIDTH +: DATA_WIDTH]),
         .din_ready   (din_ready[i]),
         .dout_valid  (dout_valid[i]),
         .dout        (dout[i*DATA_WIDTH +: DATA_WIDTH]),
         .dout_ready  (dout_ready[i]),
         .item_count  (item_count[i*CW +: CW]),
         .full        (full[i]),
         .empty       (empty[i]),
         .almost_full (almost_full[i])
`ifdef SIMPLE_MULTI_FIFO_STATS_EN
         ,
         .stats_clr   (stats_clr[i]),
         .stall_count (stall_count[i*16 +: 16])
`endif
      );
   end

endmodule

// File: tb/tb_simple_multi_fifo.sv
// Self-checking bench for simple_multi_fifo: directed phases with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based model.

module tb_simple_multi_fifo;

   localparam int CH    = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int THR   = 28;
   localparam int CW    = AW + 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [CH-1:0]      clear, din_valid, dout_ready;
   logic [CH*DW-1:0]   din;
   logic [CH-1:0]      din_ready, dout_valid, full, empty, almost_full;
   logic [CH*DW-1:0]   dout;
   logic [CH*CW-1:0]   item_count;
`ifdef SIMPLE_MULTI_FIFO_STATS_EN
   logic [CH-1:0]      stats_clr;
   logic [CH*16-1:0]   stall_count;
`endif

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;
   logic [DW-1:0] mq [CH][$];

   simple_multi_fifo #(.CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(THR)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .din_valid(din_valid), .din(din),
      .din_ready(din_ready), .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
      .item_count(item_count), .full(full), .empty(empty), .almost_full(almost_full)
`ifdef SIMPLE_MULTI_FIFO_STATS_EN
      , .stats_clr(stats_clr), .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s ch%0d got %0h expected %0h at %0t", nm, c, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] dout_of(input int c);
      return dout[c*DW +: DW];
   endfunction

   function automatic logic [CW-1:0] cnt_of(input int c);
      return item_count[c*CW +: CW];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: each queue is a plain FIFO of words.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) mq[c].delete();
         armed = 1'b1;
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (clear[c]) mq[c].delete();
            else begin
               bit e, d;
               e = din_valid[c] && (mq[c].size() < DEPTH);
               d = dout_ready[c] && (mq[c].size() > 0);
               if (d) void'(mq[c].pop_front());
               if (e) mq[c].push_back(din[c*DW +: DW]);
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (armed) begin
         for (int c = 0; c < CH; c++) begin
            int sz;
            sz = mq[c].size();
            chk("count", c, 64'(cnt_of(c)), 64'(sz));
            chk("full", c, 64'(full[c]), 64'(sz == DEPTH));
            chk("empty", c, 64'(empty[c]), 64'(sz == 0));
            chk("afull", c, 64'(almost_full[c]), 64'(sz >= THR));
            chk("dout_valid", c, 64'(dout_valid[c]), 64'(sz > 0));
            chk("din_ready", c, 64'(din_ready[c]), 64'((sz < DEPTH) && rst_n && !clear[c]));
            if (sz > 0) chk("dout", c, 64'(dout_of(c)), 64'(mq[c][0]));
         end
      end
   end

   initial begin
      rst_n = 1'b0; clear = '0; din_valid = '0; dout_ready = '0; din = '0;
`ifdef SIMPLE_MULTI_FIFO_STATS_EN
      stats_clr = '0;
`endif
      step(); step();
      rst_n = 1'b1;
      for (int c = 0; c < CH; c++) begin
         chk("rst_empty", c, 64'(empty[c]), 64'd1);
         chk("rst_count", c, 64'(cnt_of(c)), 64'd0);
      end

      // Fill channel 0 with 0..31.
      for (int k = 0; k < DEPTH; k++) begin
         din_valid[0] = 1'b1; din[0 +: DW] = DW'(k);
         step();
         chk("fill_afull", 0, 64'(almost_full[0]), 64'(k + 1 >= 28));
      end
      din_valid = '0;
      chk("fill_full", 0, 64'(full[0]), 64'd1);
      chk("fill_count", 0, 64'(cnt_of(0)), 64'd32);
      chk("fill_ready", 0, 64'(din_ready[0]), 64'd0);
      for (int c = 1; c < CH; c++) chk("other_empty", c, 64'(empty[c]), 64'd1);

      // Drain in order.
      dout_ready[0] = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         chk("drain_valid", 0, 64'(dout_valid[0]), 64'd1);
         chk("drain_data", 0, 64'(dout_of(0)), 64'(k));
         step();
      end
      dout_ready = '0;
      chk("drain_empty", 0, 64'(empty[0]), 64'd1);
      chk("drain_count", 0, 64'(cnt_of(0)), 64'd0);

      // Hold 5 words while streaming 100 through; pointers wrap repeatedly.
      for (int k = 0; k < 5; k++) begin
         din_valid[0] = 1'b1; din[0 +: DW] = DW'(1000 + k);
         step();
      end
      for (int k = 0; k < 100; k++) begin
         din_valid[0] = 1'b1; dout_ready[0] = 1'b1; din[0 +: DW] = DW'(2000 + k);
         chk("wrap_data", 0, 64'(dout_of(0)), (k < 5) ? 64'(1000 + k) : 64'(2000 + k - 5));
         step();
         chk("wrap_count", 0, 64'(cnt_of(0)), 64'd5);
      end
      din_valid = '0; dout_ready = '0;

      // Per-channel clear racing a write.
      for (int k = 0; k < 10; k++) begin
         din_valid[1] = 1'b1; din[DW +: DW] = DW'(300 + k);
         din_valid[2] = 1'b1; din[2*DW +: DW] = DW'(400 + k);
         step();
      end
      din_valid = '0;
      clear[1] = 1'b1; din_valid[1] = 1'b1; din[DW +: DW] = 32'hDEAD;
      #1;
      chk("clr_ready", 1, 64'(din_ready[1]), 64'd0);
      step();
      clear = '0; din_valid = '0;
      chk("clr_count", 1, 64'(cnt_of(1)), 64'd0);
      chk("clr_empty", 1, 64'(empty[1]), 64'd1);
      chk("clr_other", 2, 64'(cnt_of(2)), 64'd10);

      // Bring every channel to half full, then reset under traffic.
      for (int k = 0; k < 16; k++) begin
         for (int c = 0; c < CH; c++) begin
            din_valid[c] = (cnt_of(c) < 16);
            din[c*DW +: DW] = $urandom;
         end
         step();
      end
      din_valid = '1; dout_ready = '1; rst_n = 1'b0;
      #1;
      for (int c = 0; c < CH; c++) chk("rst_ready", c, 64'(din_ready[c]), 64'd0);
      step();
      rst_n = 1'b1; din_valid = '0; dout_ready = '0;
      for (int c = 0; c < CH; c++) begin
         chk("mrst_count", c, 64'(cnt_of(c)), 64'd0);
         chk("mrst_flags", c, 64'({empty[c], full[c], almost_full[c]}), 64'b100);
      end
      din_valid[2] = 1'b1; din[2*DW +: DW] = 32'h5A5A;
      step();
      din_valid = '0;
      chk("post_rst_valid", 2, 64'(dout_valid[2]), 64'd1);
      chk("post_rst_data", 2, 64'(dout_of(2)), 64'h5A5A);
      dout_ready[2] = 1'b1;
      step();
      dout_ready = '0;

`ifdef SIMPLE_MULTI_FIFO_STATS_EN
      stats_clr = '1;
      step();
      stats_clr = '0;
      din_valid[3] = 1'b1;
      for (int k = 0; k < DEPTH + 40; k++) begin
         din[3*DW +: DW] = DW'(k);
         step();
      end
      din_valid = '0;
      chk("stall_cnt", 3, 64'(stall_count[3*16 +: 16]), 64'd40);
      for (int c = 0; c < 3; c++) chk("stall_other", c, 64'(stall_count[c*16 +: 16]), 64'd0);
      stats_clr[3] = 1'b1;
      step();
      stats_clr = '0;
      chk("stall_clr", 3, 64'(stall_count[3*16 +: 16]), 64'd0);
`endif

      // Randomized traffic with shifting push/pop bias, clears and resets.
      begin
         int wp, rp;
         wp = 50; rp = 50;
         for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
               wp = $urandom_range(10, 90);
               rp = $urandom_range(10, 90);
            end
            for (int c = 0; c < CH; c++) begin
               din_valid[c]    = ($urandom_range(0, 99) < wp);
               dout_ready[c]   = ($urandom_range(0, 99) < rp);
               clear[c]        = ($urandom_range(0, 63) == 0);
               din[c*DW +: DW] = $urandom;
            end
            rst_n = ($urandom_range(0, 249) != 0);
            step();
         end
      end
      rst_n = 1'b1; clear = '0; din_valid = '0; dout_ready = '0;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
